one_to_4_router: RTL and testbench

ONE_TO_4_ROUTER -- requirements
Module: one_to_4_router

---
 rtl/one_to_4_router.sv | 112 +++++++++++
 tb/tb_one_to_4_router.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_to_4_router.sv
// -----------------------------------------------------------------------------
// one_to_4_router
//
// Routes a single valid/ready input stream onto one of four output lanes.
// Each lane owns a one-entry buffer (EMPTY / FULL). A beat accepted on a
// rising edge appears on its lane one cycle later. Lanes are independent, so
// a stalled lane never blocks traffic to the others.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1. Valid must not depend on ready. Once valid is raised, the producer
// holds valid and data stable until the transfer. in_ready is combinational
// from Sel, the lane state and out_ready. It does not depend on in_valid.
//
// Optional feature: define ROUTER_XFER_CNT_EN to add the 32-bit xfer_count
// port. It counts accepted input beats and wraps at 32'hFFFFFFFF.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   Sel        : destination lane of the input beat (0..3 -> output_1..4)
//   in_valid   : input beat present
//   in_ready   : router can accept the input beat this cycle
//   input_1    : input beat data
//   output_1-4 : lane data, driven from the lane buffers
//   out_valid  : bit k set when lane k+1 is FULL (mirrors the lane FSM state)
//   out_ready  : bit k set when the lane k+1 consumer accepts this cycle
//   xfer_count : accepted-beat counter (ROUTER_XFER_CNT_EN only)
// -----------------------------------------------------------------------------
module one_to_4_router #(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] input_1,
  output logic [DWIDTH-1:0] output_1,
  output logic [DWIDTH-1:0] output_2,
  output logic [DWIDTH-1:0] output_3,
  output logic [DWIDTH-1:0] output_4,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready
`ifdef ROUTER_XFER_CNT_EN
  ,
  output logic [31:0]       xfer_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t       lane_state [4];
  logic [DWIDTH-1:0] lane_data  [4];
  logic              in_xfer;

  // A lane can accept when it is empty, or when its buffered beat leaves
  // on the same edge.
  assign in_ready = (lane_state[Sel] == EMPTY) || out_ready[Sel];
  assign in_xfer  = in_valid && in_ready;

  // Lane FSMs. The data registers load only on an input transfer, so an
  // EMPTY lane keeps presenting its last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        lane_state[k] <= EMPTY;
        lane_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (in_xfer && (Sel == 2'(k))) begin
          // EMPTY->FULL, or FULL->FULL with the data replaced.
          lane_state[k] <= FULL;
          lane_data[k]  <= input_1;
        end else if ((lane_state[k] == FULL) && out_ready[k]) begin
          lane_state[k] <= EMPTY;
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (lane_state[k] == FULL);
    end
  end

  assign output_1 = lane_data[0];
  assign output_2 = lane_data[1];
  assign output_3 = lane_data[2];
  assign output_4 = lane_data[3];

`ifdef ROUTER_XFER_CNT_EN
  logic [31:0] xfer_cnt_q;

  // The counter wraps naturally from 32'hFFFFFFFF to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_q <= '0;
    end else if (in_xfer) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_one_to_4_router.sv
// -----------------------------------------------------------------------------
// tb_one_to_4_router
//
// Self-checking bench for one_to_4_router (DWIDTH = 64).
//
// The bench keeps its own model of lane occupancy and one expected-data queue
// per lane. A monitor runs 1 ns before each rising edge. At that point it
// checks in_ready, out_valid and the lane data against the model. It then
// pops the queue for each lane that completes an output transfer and pushes
// the accepted input beat.
// -----------------------------------------------------------------------------
module tb_one_to_4_router;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [1:0]   Sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_1;
  logic [W-1:0] output_1, output_2, output_3, output_4;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef ROUTER_XFER_CNT_EN
  logic [31:0]  xfer_count;
  logic [31:0]  exp_cnt;
`endif

  one_to_4_router #(.DWIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Sel       (Sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_1   (input_1),
    .output_1  (output_1),
    .output_2  (output_2),
    .output_3  (output_3),
    .output_4  (output_4),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ROUTER_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q3[$];
  logic [3:0]   model_full = 4'b0000;
  logic         last_acc   = 1'b0;

  function automatic int q_size(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic logic [W-1:0] q_front(input int k);
    case (k)
      0: return exp_q0[0];
      1: return exp_q1[0];
      2: return exp_q2[0];
      default: return exp_q3[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      2: void'(exp_q2.pop_front());
      default: void'(exp_q3.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input logic [W-1:0] d);
    case (k)
      0: exp_q0.push_back(d);
      1: exp_q1.push_back(d);
      2: exp_q2.push_back(d);
      default: exp_q3.push_back(d);
    endcase
  endtask

  function automatic logic [W-1:0] lane_out(input int k);
    case (k)
      0: return output_1;
      1: return output_2;
      2: return output_3;
      default: return output_4;
    endcase
  endfunction

  // Monitor: runs 1 ns before every rising edge.
  initial begin
    forever begin
      logic       exp_rdy;
      logic [3:0] nxt_full;
      @(negedge clk);
      #4;
      if (reset) begin
        model_full = 4'b0000;
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
        last_acc = 1'b0;
`ifdef ROUTER_XFER_CNT_EN
        exp_cnt = 32'd0;
`endif
      end else begin
        exp_rdy = !model_full[Sel] || out_ready[Sel];
        check("in_ready", W'(in_ready), W'(exp_rdy));
        check("out_valid", W'(out_valid), W'(model_full));
`ifdef ROUTER_XFER_CNT_EN
        check("xfer_count", W'(xfer_count), W'(exp_cnt));
`endif
        nxt_full = model_full;
        for (int k = 0; k < 4; k++) begin
          if (model_full[k]) begin
            if (q_size(k) == 0) begin
              check($sformatf("lane%0d_q_underflow", k), W'(1), W'(0));
            end else begin
              check($sformatf("lane%0d_data", k), lane_out(k), q_front(k));
              if (out_ready[k]) begin
                q_pop(k);
                nxt_full[k] = 1'b0;
              end
            end
          end
        end
        last_acc = in_valid && in_ready;
        if (in_valid && exp_rdy) begin
          q_push(int'(Sel), input_1);
          nxt_full[Sel] = 1'b1;
`ifdef ROUTER_XFER_CNT_EN
          exp_cnt = exp_cnt + 32'd1;
`endif
        end
        model_full = nxt_full;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 1'b0;
    Sel      = 2'($urandom_range(0, 3));
    input_1  = {$urandom, $urandom};
  endtask

  // Holds the beat until the router accepts it, with a bounded wait.
  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    int n = 0;
    Sel = s; input_1 = d; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("send_timeout", W'(0), W'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_output_1", output_1, '0);
    check("rst_output_2", output_2, '0);
    check("rst_output_3", output_3, '0);
    check("rst_output_4", output_4, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
`ifdef ROUTER_XFER_CNT_EN
    check("rst_xfer_count", W'(xfer_count), W'(0));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    bit done;
    reset = 1'b1; out_ready = 4'b1111;
    idle();
    do_reset(2);
    check_reset_state();

    // Single beat to lane 3 (Sel=2).
    send(2'd2, 64'hA5A5);
    check("sel2_out_valid", W'(out_valid), W'(4'b0100));
    check("sel2_output_3", output_3, 64'hA5A5);
    idle();
    @(negedge clk);
    check("sel2_drained", W'(out_valid), W'(0));

    // Backpressure on lane 1: the second beat waits until 64'h1 is consumed.
    out_ready = 4'b1110;
    send(2'd0, 64'h1);
    fork
      send(2'd0, 64'h2);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", W'(in_ready), W'(0));
        check("bp_output_1_hold", output_1, 64'h1);
        out_ready[0] = 1'b1;
      end
    join
    idle();
    @(negedge clk);
    @(negedge clk);

    // Stalled lane 2 must not block lane 4.
    out_ready = 4'b1101;
    send(2'd1, 64'h5);
    send(2'd3, 64'h7);
    check("indep_output_4", output_4, 64'h7);
    check("indep_out_valid", W'(out_valid), W'(4'b1010));
    idle();
    out_ready = 4'b1111;
    repeat (2) @(negedge clk);

    // Back-to-back beats to lane 2, one per cycle.
    t0 = cycle;
    for (int i = 1; i <= 8; i++) send(2'd1, W'(i));
    check("b2b_cycles", W'(cycle - t0), W'(8));
    idle();
    repeat (2) @(negedge clk);

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(2'($urandom_range(0, 3)), {$urandom, $urandom});
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(negedge clk);
          end
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 4'($urandom_range(0, 15));
        end
      end
    join
    out_ready = 4'b1111;
    repeat (3) @(negedge clk);
    check("drain_out_valid", W'(out_valid), W'(0));
    check("drain_queues", W'(q_size(0) + q_size(1) + q_size(2) + q_size(3)), W'(0));

    // Fill every lane and then reset.
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send(2'(k), W'(64'h100 + k));
    check("fill_out_valid", W'(out_valid), W'(4'b1111));
    do_reset(1);
    check_reset_state();
    out_ready = 4'b1111;

`ifdef ROUTER_XFER_CNT_EN
    // Counter wrap: preload to 32'hFFFFFFFE, then accept two beats.
    @(negedge clk);
    force dut.xfer_cnt_q = 32'hFFFFFFFE;
    exp_cnt = 32'hFFFFFFFE;
    #1 release dut.xfer_cnt_q;
    send(2'd0, 64'h11);
    check("cnt_ffffffff", W'(xfer_count), W'(32'hFFFFFFFF));
    send(2'd1, 64'h22);
    check("cnt_wrap", W'(xfer_count), W'(0));
    idle();
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
